// File: rtl/fp_add_pkg.sv
// Shared constants and operand classification for the
// registered single-precision adder.
package fp_add_pkg;

  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Denormals have exp=0 and are treated as zero.
  function automatic fp_class_t classify(
    input logic [31:0] x
  );
    fp_class_t c;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    e = x[30:23];
    f = x[22:0];
    c.is_nan = (e == EXP_MAX) && (f != '0);
    c.is_inf = (e == EXP_MAX) && (f == '0);
    c.is_zero = (e == '0);
    return c;
  endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational IEEE-754 single adder: truncating,
// flush-to-zero, with special-case flags.
module fp_add_core
  import fp_add_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        nan,
  output logic        inf,
  output logic        neg_inf,
  output logic        err
);

  fp_class_t ca;
  fp_class_t cb;
  logic [31:0] big;
  logic [31:0] sml;
  logic [7:0] ed;
  logic [23:0] mb;
  logic [23:0] ms;
  logic [23:0] msh;
  logic same;
  logic [24:0] sum;
  logic [4:0] lz;
  logic [23:0] norm;
  logic [22:0] frac;
  logic signed [9:0] e;
  logic inf_sign;

  assign ca = classify(a);
  assign cb = classify(b);

  assign big = (a[30:0] >= b[30:0]) ? a : b;
  assign sml = (a[30:0] >= b[30:0]) ? b : a;
  assign ed = big[30:23] - sml[30:23];
  assign mb = {1'b1, big[22:0]};
  assign ms = {1'b1, sml[22:0]};
  assign msh = (ed >= 8'd24) ? '0 : (ms >> ed);
  assign same = (big[31] == sml[31]);
  assign sum = same ? ({1'b0, mb} + {1'b0, msh})
                    : ({1'b0, mb} - {1'b0, msh});

  // Leading-zero count of the 24-bit difference.
  always_comb begin
    lz = '0;
    for (int i = 0; i < 24; i++) begin
      if (sum[i]) lz = 5'(23 - i);
    end
  end

  always_comb begin
    norm = sum[23:0] << lz;
    if (sum[24]) begin
      frac = sum[23:1];
      e = $signed({2'b00, big[30:23]}) + 10'sd1;
    end else begin
      frac = norm[22:0];
      e = $signed({2'b00, big[30:23]})
        - $signed({5'b00000, lz});
    end
  end

  assign inf_sign = ca.is_inf ? a[31] : b[31];

  always_comb begin
    result = '0;
    nan = 1'b0;
    inf = 1'b0;
    neg_inf = 1'b0;
    err = 1'b0;
    if (ca.is_nan || cb.is_nan ||
        (ca.is_inf && cb.is_inf && a[31] != b[31])) begin
      result = QNAN;
      nan = 1'b1;
      err = 1'b1;
    end else if (ca.is_inf || cb.is_inf) begin
      result = inf_sign ? NEG_INF : POS_INF;
      inf = !inf_sign;
      neg_inf = inf_sign;
    end else if (ca.is_zero && cb.is_zero) begin
      result = '0;
    end else if (ca.is_zero) begin
      result = b;
    end else if (cb.is_zero) begin
      result = a;
    end else if (sum == '0) begin
      result = '0;
    end else if (e >= 10'sd255) begin
      result = big[31] ? NEG_INF : POS_INF;
      inf = !big[31];
      neg_inf = big[31];
    end else if (e <= 10'sd0) begin
      result = '0;
    end else begin
      result = {big[31], e[7:0], frac};
    end
  end

endmodule

// File: rtl/floating_point_adder.sv
// Two register stages around the combinational adder:
// fixed 2-cycle latency, one operand pair per cycle.
module floating_point_adder
  import fp_add_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_reg,
  input  logic [31:0] b_reg,
  output logic [31:0] result_reg,
  output logic        NAN_reg,
  output logic        INF_reg,
  output logic        NEG_INF_reg,
  output logic        ERR_reg
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_d;
  logic nan_d;
  logic inf_d;
  logic ninf_d;
  logic err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_reg;
      b_q <= b_reg;
    end
  end

  fp_add_core u_core (
    .a       (a_q),
    .b       (b_q),
    .result  (res_d),
    .nan     (nan_d),
    .inf     (inf_d),
    .neg_inf (ninf_d),
    .err     (err_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg <= '0;
      NAN_reg <= 1'b0;
      INF_reg <= 1'b0;
      NEG_INF_reg <= 1'b0;
      ERR_reg <= 1'b0;
    end else begin
      result_reg <= res_d;
      NAN_reg <= nan_d;
      INF_reg <= inf_d;
      NEG_INF_reg <= ninf_d;
      ERR_reg <= err_d;
    end
  end

endmodule

// File: tb/tb_floating_point_adder.sv
// Bench for floating_point_adder: directed table plus
// random operands against an arithmetic reference model.
module tb_floating_point_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a_reg = '0;
  logic [31:0] b_reg = '0;
  logic [31:0] result_reg;
  logic NAN_reg;
  logic INF_reg;
  logic NEG_INF_reg;
  logic ERR_reg;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0] flg;
    string name;
  } vec_t;

  vec_t v[$];

  floating_point_adder dut (
    .clk         (clk),
    .rst         (rst),
    .a_reg       (a_reg),
    .b_reg       (b_reg),
    .result_reg  (result_reg),
    .NAN_reg     (NAN_reg),
    .INF_reg     (INF_reg),
    .NEG_INF_reg (NEG_INF_reg),
    .ERR_reg     (ERR_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Returns {result, nan, inf, neg_inf, err}.
  function automatic logic [35:0] ref_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int ea, eb, el, es, d, e;
    longint fa, fb, ml, ms, s;
    bit sa, sb, sl, na, nb, ia, ib, za, zb;
    logic [31:0] r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    sa = a[31];
    sb = b[31];
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (ia && ib && sa != sb))
      return {32'h7FC00000, 4'b1001};
    if (ia || ib) begin
      sl = ia ? sa : sb;
      if (sl) return {32'hFF800000, 4'b0010};
      return {32'h7F800000, 4'b0100};
    end
    if (za && zb) return '0;
    if (za) return {b, 4'b0000};
    if (zb) return {a, 4'b0000};
    if (a[30:0] >= b[30:0]) begin
      el = ea; es = eb; sl = sa;
      ml = (64'd1 << 23) + fa;
      ms = (64'd1 << 23) + fb;
    end else begin
      el = eb; es = ea; sl = sb;
      ml = (64'd1 << 23) + fb;
      ms = (64'd1 << 23) + fa;
    end
    d = el - es;
    ms = (d >= 24) ? 0 : ms / (64'd1 << d);
    s = (sa == sb) ? ml + ms : ml - ms;
    if (s == 0) return '0;
    e = el;
    while (s >= (64'd1 << 24)) begin
      s = s / 2;
      e++;
    end
    while (s < (64'd1 << 23)) begin
      s = s * 2;
      e--;
    end
    if (e >= 255) begin
      if (sl) return {32'hFF800000, 4'b0010};
      return {32'h7F800000, 4'b0100};
    end
    if (e <= 0) return '0;
    r = {sl, 8'(e), 23'(s - (64'd1 << 23))};
    return {r, 4'b0000};
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: x[30:23] = 8'h00;
      1: begin
        x[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) x[22:0] = '0;
      end
      2: x[30:23] = 8'($urandom_range(248, 254));
      3: x[30:23] = 8'($urandom_range(1, 6));
      default: x[30:23] = 8'($urandom_range(110, 150));
    endcase
    return x;
  endfunction

  task automatic add_vec(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] r,
    input logic [3:0] f,
    input string n
  );
    vec_t t;
    t.a = a; t.b = b; t.res = r; t.flg = f; t.name = n;
    v.push_back(t);
  endtask

  task automatic check(
    input string n,
    input logic [35:0] want
  );
    logic [35:0] got;
    got = {result_reg, NAN_reg, INF_reg,
           NEG_INF_reg, ERR_reg};
    checks++;
    if (got === want) passed++;
    else
      $display("FAIL %s: got %h/%b want %h/%b", n,
               got[35:4], got[3:0], want[35:4], want[3:0]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [35:0] m;
    int n;

    add_vec(32'h7F800000, 32'h7F000008,
            32'h7F800000, 4'b0100, "inf+fin");
    add_vec(32'hFF800000, 32'h7F000008,
            32'hFF800000, 4'b0010, "ninf+fin");
    add_vec(32'hFF800000, 32'hFF800000,
            32'hFF800000, 4'b0010, "ninf+ninf");
    add_vec(32'h7F800002, 32'h7F800001,
            32'h7FC00000, 4'b1001, "nan+nan");
    add_vec(32'h7F800000, 32'hFF800000,
            32'h7FC00000, 4'b1001, "inf-inf");
    add_vec(32'h43663BE7, 32'h4728F8E0,
            32'h4729DF1B, 4'b0000, "add pos");
    add_vec(32'hC3663BE7, 32'hC728F8E0,
            32'hC729DF1B, 4'b0000, "add neg");
    add_vec(32'h43663BE7, 32'hC728F8E0,
            32'hC72812A5, 4'b0000, "sub neg");
    add_vec(32'hC3663BE7, 32'h4728F8E0,
            32'h472812A5, 4'b0000, "sub pos");
    add_vec(32'hC3663BE7, 32'h43663BE7,
            32'h00000000, 4'b0000, "cancel");
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF,
            32'h7F800000, 4'b0100, "overflow");
    add_vec(32'h00000000, 32'hC0490FDB,
            32'hC0490FDB, 4'b0000, "zero+x");
    add_vec(32'h80000000, 32'h00000000,
            32'h00000000, 4'b0000, "zero+zero");
    add_vec(32'h3F800000, 32'h33800000,
            32'h3F800000, 4'b0000, "shift24");
    add_vec(32'h00800001, 32'h80800000,
            32'h00000000, 4'b0000, "underflow");
    add_vec(32'h3F800000, 32'h3F800000,
            32'h40000000, 4'b0000, "1+1");

    for (int i = 0; i < 300; i++) begin
      ra = rnd_float();
      rb = rnd_float();
      if ($urandom_range(0, 4) == 0)
        rb = {~ra[31], ra[30:8], 8'($urandom)};
      m = ref_add(ra, rb);
      add_vec(ra, rb, m[35:4], m[3:0], "random");
    end

    #1 rst = 1'b0;
    #2 check("reset state", 36'h0);
    @(negedge clk);
    rst = 1'b1;

    n = v.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) check(v[k-2].name, {v[k-2].res, v[k-2].flg});
      if (k < n) begin
        a_reg = v[k].a;
        b_reg = v[k].b;
      end else begin
        a_reg = '0;
        b_reg = '0;
      end
    end

    @(negedge clk);
    a_reg = 32'h7F7FFFFF;
    b_reg = 32'h7F7FFFFF;
    @(negedge clk);
    a_reg = 32'h43663BE7;
    b_reg = 32'h4728F8E0;
    @(posedge clk);
    #2 check("pre-reset", {32'h7F800000, 4'b0100});
    rst = 1'b0;
    #1 check("async reset", 36'h0);
    a_reg = '0;
    b_reg = '0;
    @(negedge clk);
    check("reset held", 36'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 check("flushed inflight", 36'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/floating_point_adder.md
Name: floating_point_adder

Overview:
- Registered IEEE-754 single-precision adder: adds two 32-bit floats and reports special-case flags.
- Both inputs and outputs are registered, giving a fixed 2-cycle latency with no handshake.
- Sits as a standalone arithmetic datapath block. Rounding is truncation and denormals are flushed to zero.

Parameters:
- None. Format is fixed: 1 sign, 8 exponent, 23 fraction bits, bias 127.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- a_reg  in  32  operand A (IEEE-754 single)
- b_reg  in  32  operand B (IEEE-754 single)
- result_reg  out  32  registered sum
- NAN_reg  out  1  result is NaN
- INF_reg  out  1  result is +infinity
- NEG_INF_reg  out  1  result is -infinity
- ERR_reg  out  1  invalid operation

Behaviour:
- Reset (rst=0, asynchronous): input registers, result_reg, NAN_reg, INF_reg, NEG_INF_reg and ERR_reg all clear to 0.
- Pipeline:
  - Edge 1 captures a_reg/b_reg into internal input registers.
  - A combinational adder computes from those registers.
  - Edge 2 captures the result and flags into the output registers.
  - Latency: 2 cycles. A new operand pair is accepted every cycle.
- Classification per operand:
  - exp=255, frac=0 → ±inf.
  - exp=255, frac≠0 → NaN.
  - exp=0 → zero (denormals flushed, sign ignored).
  - Otherwise normal with hidden 1.
- Priority, highest first:
  1. Any NaN operand → result 0x7FC00000, NAN=1, ERR=1.
  2. +inf plus -inf → result 0x7FC00000, NAN=1, ERR=1.
  3. Any inf (same-sign infs, or inf plus finite) → result is that signed infinity.
     - +inf: result 0x7F800000, INF=1.
     - -inf: result 0xFF800000, NEG_INF=1.
  4. Both operands zero → 0x00000000.
  5. One operand zero → the other operand unchanged.
  6. Finite arithmetic, below.
- Finite arithmetic:
  - Order operands by magnitude ({exp,frac} compare); the larger sets the result sign.
  - Shift the smaller 24-bit significand right by the exponent difference. Shifted-out bits are discarded, with no guard/round/sticky bits. A difference of 24 or more makes it 0.
  - Same signs: add into a 25-bit sum. On carry-out, shift right 1 (truncating the LSB) and increment the exponent.
  - Different signs: subtract smaller from larger. Normalize left via leading-zero count and decrement the exponent by the same count.
  - A zero difference gives 0x00000000 (positive zero).
  - Exponent reaching 255 → signed infinity with INF or NEG_INF set.
  - Exponent at or below 0 after normalization → 0x00000000.
  - Rounding: truncation toward zero.
- Flag rules:
  - At most one of NAN/INF/NEG_INF is set in any cycle.
  - ERR equals the invalid-operation condition (cases 1–2) and is otherwise 0.
- Reset asserted mid-operation: everything in flight is discarded and outputs go to 0 immediately.

Decomposition:
- Package fp_add_pkg holds:
  - Constants: EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF, QNAN=32'h7FC00000, POS_INF=32'h7F800000, NEG_INF=32'hFF800000.
  - Classification function (is_nan, is_inf, is_zero).
- One combinational sub-module, fp_add_core: operands in; result, nan, inf, neg_inf, err out.
- Top level is the two register stages around fp_add_core.

Test Plan:
- a=0x7F800000, b=0x7F000008 → after 2 cycles result 0x7F800000, INF=1, other flags 0.
- a=0xFF800000, b=0x7F000008 → result 0xFF800000, NEG_INF=1. Also -inf + -inf → same result and flag.
- a=0x7F800002, b=0x7F800001 → NAN=1, ERR=1, result 0x7FC00000. Also +inf + -inf → same.
- Truncating same-sign sum and its negation:
  - 0x43663BE7 + 0x4728F8E0 → 0x4729DF1B.
  - 0xC3663BE7 + 0xC728F8E0 → 0xC729DF1B.
- Truncating opposite-sign difference:
  - 0x43663BE7 + 0xC728F8E0 → 0xC72812A5.
  - 0xC3663BE7 + 0x4728F8E0 → 0x472812A5.
- Cancellation, boundaries and reset:
  - 0xC3663BE7 + 0x43663BE7 → 0x00000000, all flags 0.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, INF=1.
  - Back-to-back operand pairs each appear exactly 2 cycles later.
  - rst low mid-stream clears all outputs immediately.
